ex_operand_forward_unit: RTL and testbench
==========================================

EX_OPERAND_FORWARD_UNIT -- requirements
Module: ex_operand_forward_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand/data width in bits.
REQ-002 The block SHALL have clk  input  1  rising-edge clock.
REQ-003 The block SHALL have reset  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have id_valid  input  1  ID-stage instruction valid.
REQ-005 The block SHALL have rs1_addr_id, rs2_addr_id  input  5 each  ID-stage source register addresses.
REQ-006 The block SHALL have rs1_data_id, rs2_data_id  input  XLEN each  register-file read data.
REQ-007 The block SHALL have fwd_rs1_mem, fwd_rs2_mem, fwd_rs1_wb, fwd_rs2_wb  input  1 each  forward enables from the ALU hazard unit.
REQ-008 The block SHALL have alu_result_mem  input  XLEN  MEM-stage result; mem_is_load  input  1  MEM-stage instruction is a load.
REQ-009 The block SHALL have wb_data  input  XLEN  WB-stage write-back value.
REQ-010 The block SHALL have operand_a, operand_b  output  XLEN each  registered EX operands; ex_valid  output  1  operands valid.
REQ-011 The block SHALL have stall_id  output  1  registered request to hold IF/ID and insert a bubble.

Function
REQ-012 Forward enables SHALL be qualified: a rsN enable is ignored when rsN_addr_id == 0 (x0 never forwarded).
REQ-013 Per operand, priority SHALL be MEM over WB over register file: qualified mem enable -> alu_result_mem; else qualified wb enable -> wb_data; else rsN_data_id.
REQ-014 FSM states SHALL be RUN and LOAD_STALL; reset state RUN.
REQ-015 In RUN, load-use hazard = id_valid & mem_is_load & (qualified fwd_rs1_mem | qualified fwd_rs2_mem).
REQ-016 RUN, no hazard: at clk edge operand_a/b latch the REQ-013 selection, ex_valid <= id_valid, stall_id <= 0, stay RUN.
REQ-017 RUN, hazard: at clk edge capture pend_rs1/pend_rs2 (which operands needed MEM data), rs1/rs2_data_id, and the non-pending operands' WB-forward selection; ex_valid <= 0, stall_id <= 1, operands hold, go LOAD_STALL.
REQ-018 LOAD_STALL: at clk edge pending operands latch wb_data, non-pending operands latch their captured values; ex_valid <= 1, stall_id <= 0, go RUN.
REQ-019 LOAD_STALL SHALL last exactly one cycle; ID inputs are don't-care during it.
REQ-020 Latency: operands SHALL appear one cycle after ID presentation (two with a load-use stall).
REQ-021 Both operands pending on the same load SHALL both receive wb_data in the single stall cycle.
REQ-022 Mem and wb enables both set on one operand with mem_is_load=0 SHALL select alu_result_mem.
REQ-023 id_valid=0 SHALL never trigger a stall; operand registers may update, ex_valid <= 0.

Reset
REQ-024 On reset at clk edge: state RUN, operand_a=0, operand_b=0, ex_valid=0, stall_id=0, pending flags and captured data cleared.
REQ-025 Reset during LOAD_STALL SHALL abort the stall; no operand update from the aborted instruction.
REQ-026 Reset SHALL take priority over all other events in the same cycle.

Configuration
REQ-027 Macro FWD_STATS_EN SHALL, when defined, add outputs fwd_count [15:0] (increments once per ex_valid cycle in which any operand used forwarded data) and stall_count [15:0] (increments per LOAD_STALL entry), both saturating at 16'hFFFF, cleared by reset.
REQ-028 Without FWD_STATS_EN the counters and ports SHALL be absent; all other behaviour identical.

Verification
REQ-029 rs1=5, fwd_rs1_mem=1, mem_is_load=0, alu_result_mem=0x11, rs1_data=0x99 -> next cycle operand_a=0x11, ex_valid=1, stall_id=0.
REQ-030 rs2=0, fwd_rs2_mem=1, fwd_rs2_wb=1, rs2_data=0x0 -> operand_b=0x0 (x0 suppression).
REQ-031 rs1=rs2=7, fwd_rs1_mem=fwd_rs2_mem=1, mem_is_load=1 -> stall_id=1, ex_valid=0; next cycle wb_data=0xABCD -> operand_a=operand_b=0xABCD, ex_valid=1, stall_id=0.
REQ-032 fwd_rs1_mem=1, fwd_rs1_wb=1, mem_is_load=0, alu_result_mem=0x22, wb_data=0x33 -> operand_a=0x22.
REQ-033 Enter LOAD_STALL, assert reset next cycle -> outputs all 0, state RUN, ex_valid=0; FWD_STATS_EN build: stall_count=0.
REQ-034 FWD_STATS_EN build: 3 forwarded instructions + 2 load-use stalls -> fwd_count=5 (stalled ones count once), stall_count=2.

Source files
------------

// File: rtl/ex_operand_forward_unit.sv
// EX operand forwarding with load-use stall handling; registers the EX operands.
// Define FWD_STATS_EN to add the fwd_count/stall_count statistics outputs.
module ex_operand_forward_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      rs1_addr_id,
    input  logic [4:0]      rs2_addr_id,
    input  logic [XLEN-1:0] rs1_data_id,
    input  logic [XLEN-1:0] rs2_data_id,
    input  logic            fwd_rs1_mem,
    input  logic            fwd_rs2_mem,
    input  logic            fwd_rs1_wb,
    input  logic            fwd_rs2_wb,
    input  logic [XLEN-1:0] alu_result_mem,
    input  logic            mem_is_load,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic            ex_valid,
    output logic            stall_id
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]     fwd_count,
    output logic [15:0]     stall_count
`endif
);

    typedef enum logic {RUN, LOAD_STALL} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] operand_a_q, operand_a_d;
    logic [XLEN-1:0] operand_b_q, operand_b_d;
    logic            ex_valid_q, ex_valid_d;
    logic            stall_id_q, stall_id_d;
    logic            pend_rs1_q, pend_rs1_d;
    logic            pend_rs2_q, pend_rs2_d;
    logic [XLEN-1:0] cap_a_q, cap_a_d;
    logic [XLEN-1:0] cap_b_q, cap_b_d;

    logic            q1_mem, q2_mem, q1_wb, q2_wb;
    logic            hazard, fwd_any;
    logic            fwd_evt, stall_evt;
    logic [XLEN-1:0] wsel_a, wsel_b, sel_a, sel_b;

    // x0 is hardwired zero, so forwarding into it is suppressed
    assign q1_mem = fwd_rs1_mem && (rs1_addr_id != 5'd0);
    assign q2_mem = fwd_rs2_mem && (rs2_addr_id != 5'd0);
    assign q1_wb  = fwd_rs1_wb  && (rs1_addr_id != 5'd0);
    assign q2_wb  = fwd_rs2_wb  && (rs2_addr_id != 5'd0);

    assign wsel_a  = q1_wb  ? wb_data : rs1_data_id;
    assign wsel_b  = q2_wb  ? wb_data : rs2_data_id;
    assign sel_a   = q1_mem ? alu_result_mem : wsel_a;
    assign sel_b   = q2_mem ? alu_result_mem : wsel_b;
    assign hazard  = id_valid && mem_is_load && (q1_mem || q2_mem);
    assign fwd_any = id_valid && (q1_mem || q2_mem || q1_wb || q2_wb);

    always_comb begin
        state_d     = state_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        ex_valid_d  = ex_valid_q;
        stall_id_d  = stall_id_q;
        pend_rs1_d  = pend_rs1_q;
        pend_rs2_d  = pend_rs2_q;
        cap_a_d     = cap_a_q;
        cap_b_d     = cap_b_q;
        fwd_evt     = 1'b0;
        stall_evt   = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard) begin
                    pend_rs1_d = q1_mem;
                    pend_rs2_d = q2_mem;
                    cap_a_d    = q1_mem ? rs1_data_id : wsel_a;
                    cap_b_d    = q2_mem ? rs2_data_id : wsel_b;
                    ex_valid_d = 1'b0;
                    stall_id_d = 1'b1;
                    state_d    = LOAD_STALL;
                    stall_evt  = 1'b1;
                end else begin
                    operand_a_d = sel_a;
                    operand_b_d = sel_b;
                    ex_valid_d  = id_valid;
                    stall_id_d  = 1'b0;
                    fwd_evt     = fwd_any;
                end
            end
            LOAD_STALL: begin
                // the load result is now on the WB bus
                operand_a_d = pend_rs1_q ? wb_data : cap_a_q;
                operand_b_d = pend_rs2_q ? wb_data : cap_b_q;
                ex_valid_d  = 1'b1;
                stall_id_d  = 1'b0;
                pend_rs1_d  = 1'b0;
                pend_rs2_d  = 1'b0;
                state_d     = RUN;
                fwd_evt     = 1'b1;
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            state_d     = RUN;
            operand_a_d = '0;
            operand_b_d = '0;
            ex_valid_d  = 1'b0;
            stall_id_d  = 1'b0;
            pend_rs1_d  = 1'b0;
            pend_rs2_d  = 1'b0;
            cap_a_d     = '0;
            cap_b_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        operand_a_q <= operand_a_d;
        operand_b_q <= operand_b_d;
        ex_valid_q  <= ex_valid_d;
        stall_id_q  <= stall_id_d;
        pend_rs1_q  <= pend_rs1_d;
        pend_rs2_q  <= pend_rs2_d;
        cap_a_q     <= cap_a_d;
        cap_b_q     <= cap_b_d;
    end

    assign operand_a = operand_a_q;
    assign operand_b = operand_b_q;
    assign ex_valid  = ex_valid_q;
    assign stall_id  = stall_id_q;

`ifdef FWD_STATS_EN
    logic [15:0] fwd_count_q, fwd_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        fwd_count_d   = fwd_count_q;
        stall_count_d = stall_count_q;
        if (fwd_evt && fwd_count_q != 16'hFFFF)
            fwd_count_d = fwd_count_q + 16'd1;
        if (stall_evt && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
        if (reset) begin
            fwd_count_d   = '0;
            stall_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        fwd_count_q   <= fwd_count_d;
        stall_count_q <= stall_count_d;
    end

    assign fwd_count   = fwd_count_q;
    assign stall_count = stall_count_q;
`else
    logic unused_stats;
    assign unused_stats = fwd_evt ^ stall_evt;
`endif

endmodule

// File: tb/tb_ex_operand_forward_unit.sv
// Randomized bench for ex_operand_forward_unit with an instruction-level model.
// Directed literal cases pin the model; a negedge process compares every cycle.
module tb_ex_operand_forward_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [4:0]      rs1_addr_id, rs2_addr_id;
    logic [XLEN-1:0] rs1_data_id, rs2_data_id;
    logic            fwd_rs1_mem, fwd_rs2_mem, fwd_rs1_wb, fwd_rs2_wb;
    logic [XLEN-1:0] alu_result_mem;
    logic            mem_is_load;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] operand_a, operand_b;
    logic            ex_valid, stall_id;
`ifdef FWD_STATS_EN
    logic [15:0]     fwd_count, stall_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    ex_operand_forward_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
        .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id),
        .fwd_rs1_mem(fwd_rs1_mem), .fwd_rs2_mem(fwd_rs2_mem),
        .fwd_rs1_wb(fwd_rs1_wb), .fwd_rs2_wb(fwd_rs2_wb),
        .alu_result_mem(alu_result_mem), .mem_is_load(mem_is_load),
        .wb_data(wb_data), .operand_a(operand_a), .operand_b(operand_b),
        .ex_valid(ex_valid), .stall_id(stall_id)
`ifdef FWD_STATS_EN
        , .fwd_count(fwd_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: an instruction either issues now, or waits
    // one cycle for its load result and then issues with wb_data.
    logic [XLEN-1:0] m_a, m_b, m_cap_a, m_cap_b;
    logic            m_v, m_s, m_wait, m_p1, m_p2;
    int              m_fwd, m_stl;

    always @(posedge clk) begin
        bit u1m, u2m, u1w, u2w;
        u1m = fwd_rs1_mem && rs1_addr_id != 0;
        u2m = fwd_rs2_mem && rs2_addr_id != 0;
        u1w = fwd_rs1_wb  && rs1_addr_id != 0;
        u2w = fwd_rs2_wb  && rs2_addr_id != 0;
        if (reset) begin
            m_a = 0; m_b = 0; m_v = 0; m_s = 0; m_wait = 0;
            m_p1 = 0; m_p2 = 0; m_fwd = 0; m_stl = 0;
        end else if (m_wait) begin
            m_a = m_p1 ? wb_data : m_cap_a;
            m_b = m_p2 ? wb_data : m_cap_b;
            m_v = 1; m_s = 0; m_wait = 0;
            if (m_fwd < 65535) m_fwd++;
        end else if (id_valid && mem_is_load && (u1m || u2m)) begin
            m_p1 = u1m; m_p2 = u2m;
            m_cap_a = u1w ? wb_data : rs1_data_id;
            m_cap_b = u2w ? wb_data : rs2_data_id;
            m_v = 0; m_s = 1; m_wait = 1;
            if (m_stl < 65535) m_stl++;
        end else begin
            m_a = u1m ? alu_result_mem : (u1w ? wb_data : rs1_data_id);
            m_b = u2m ? alu_result_mem : (u2w ? wb_data : rs2_data_id);
            m_v = id_valid; m_s = 0;
            if (id_valid && (u1m || u2m || u1w || u2w) && m_fwd < 65535) m_fwd++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_operand_a", operand_a, m_a);
            check("model_operand_b", operand_b, m_b);
            check("model_ex_valid", ex_valid, m_v);
            check("model_stall_id", stall_id, m_s);
`ifdef FWD_STATS_EN
            check("model_fwd_count", fwd_count, m_fwd);
            check("model_stall_count", stall_count, m_stl);
`endif
        end
    end

    task automatic idle();
        id_valid = 0; rs1_addr_id = 0; rs2_addr_id = 0;
        rs1_data_id = 0; rs2_data_id = 0;
        fwd_rs1_mem = 0; fwd_rs2_mem = 0; fwd_rs1_wb = 0; fwd_rs2_wb = 0;
        alu_result_mem = 0; mem_is_load = 0; wb_data = 0;
    endtask

    task automatic load_use(input logic [XLEN-1:0] v);
        idle(); id_valid = 1; rs1_addr_id = 7; rs2_addr_id = 7;
        fwd_rs1_mem = 1; fwd_rs2_mem = 1; mem_is_load = 1;
        @(negedge clk);
        idle(); wb_data = v;
        @(negedge clk);
    endtask

    task automatic fwd_instr(input logic [XLEN-1:0] v);
        idle(); id_valid = 1; rs1_addr_id = 3;
        fwd_rs1_mem = 1; alu_result_mem = v;
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        check("reset_a", operand_a, 0);
        check("reset_b", operand_b, 0);
        check("reset_valid", ex_valid, 0);
        check("reset_stall", stall_id, 0);

        reset = 0;
        idle(); id_valid = 1; rs1_addr_id = 5; fwd_rs1_mem = 1;
        alu_result_mem = 32'h11; rs1_data_id = 32'h99;
        @(negedge clk);
        check("mem_fwd_a", operand_a, 32'h11);
        check("mem_fwd_valid", ex_valid, 1);
        check("mem_fwd_stall", stall_id, 0);

        idle(); id_valid = 1; rs2_addr_id = 0; fwd_rs2_mem = 1; fwd_rs2_wb = 1;
        alu_result_mem = 32'h55; wb_data = 32'h66;
        @(negedge clk);
        check("x0_suppress_b", operand_b, 0);

        idle(); id_valid = 1; rs1_addr_id = 9; fwd_rs1_mem = 1; fwd_rs1_wb = 1;
        alu_result_mem = 32'h22; wb_data = 32'h33;
        @(negedge clk);
        check("mem_over_wb_a", operand_a, 32'h22);

        idle(); id_valid = 1; rs1_addr_id = 7; rs2_addr_id = 7;
        fwd_rs1_mem = 1; fwd_rs2_mem = 1; mem_is_load = 1;
        @(negedge clk);
        check("lu_stall", stall_id, 1);
        check("lu_valid0", ex_valid, 0);
        idle(); wb_data = 32'hABCD;
        @(negedge clk);
        check("lu_a", operand_a, 32'hABCD);
        check("lu_b", operand_b, 32'hABCD);
        check("lu_valid1", ex_valid, 1);
        check("lu_stall0", stall_id, 0);

        idle(); id_valid = 1; rs1_addr_id = 4; fwd_rs1_mem = 1; mem_is_load = 1;
        @(negedge clk);
        check("abort_stall", stall_id, 1);
        idle(); wb_data = 32'h1234; reset = 1;
        @(negedge clk);
        check("abort_a", operand_a, 0);
        check("abort_b", operand_b, 0);
        check("abort_valid", ex_valid, 0);
        check("abort_stall0", stall_id, 0);
`ifdef FWD_STATS_EN
        check("abort_stall_count", stall_count, 0);
`endif
        reset = 0;
        idle(); id_valid = 1; rs1_addr_id = 2; rs1_data_id = 32'h77;
        @(negedge clk);
        check("after_abort_a", operand_a, 32'h77);

`ifdef FWD_STATS_EN
        reset = 1; idle();
        @(negedge clk);
        reset = 0;
        fwd_instr(32'h1);
        load_use(32'h2);
        fwd_instr(32'h3);
        load_use(32'h4);
        fwd_instr(32'h5);
        idle();
        @(negedge clk);
        check("stats_fwd_count", fwd_count, 5);
        check("stats_stall_count", stall_count, 2);
`endif

        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 49) == 0);
            id_valid       = $urandom_range(0, 3) != 0;
            rs1_addr_id    = 5'($urandom_range(0, 3));
            rs2_addr_id    = 5'($urandom_range(0, 3));
            rs1_data_id    = $urandom;
            rs2_data_id    = $urandom;
            fwd_rs1_mem    = $urandom_range(0, 2) == 0;
            fwd_rs2_mem    = $urandom_range(0, 2) == 0;
            fwd_rs1_wb     = $urandom_range(0, 1) == 0;
            fwd_rs2_wb     = $urandom_range(0, 1) == 0;
            alu_result_mem = $urandom;
            mem_is_load    = $urandom_range(0, 1) == 0;
            wb_data        = $urandom;
            @(negedge clk);
        end
        idle(); reset = 0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
